// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its flush controller.
package bru_pkg;

  typedef enum logic {
    BRU_IDLE  = 1'b0,
    BRU_FLUSH = 1'b1
  } bru_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int XLEN_DEF    = 32;
  localparam int GHR_W_DEF   = 4;

endpackage

// File: rtl/bru_flush_ctrl.sv
// Mispredict flush sequencer: holds flush_o high for FLUSH_CYCLES cycles after a mispredict
// and reports idle when new branches may be resolved again.
module bru_flush_ctrl
  import bru_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mispredict,
  output logic flush_o,
  output logic idle
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_t    state_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BRU_IDLE;
      cnt_q   <= '0;
      flush_o <= 1'b0;
    end else begin
      unique case (state_q)
        BRU_IDLE: begin
          if (mispredict) begin
            state_q <= BRU_FLUSH;
            cnt_q   <= '0;
            flush_o <= 1'b1;
          end
        end
        BRU_FLUSH: begin
          if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
            state_q <= BRU_IDLE;
            cnt_q   <= '0;
            flush_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= BRU_IDLE;
          cnt_q   <= '0;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

  assign idle = (state_q == BRU_IDLE);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: BPU update, fetch redirect and wrong-path flush.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int GHR_W        = GHR_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_cond_true,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_pc,
  input  logic [GHR_W-1:0] ex_ghr,
  output logic             branch_resolved,
  output logic             branch_taken,
  output logic [XLEN-1:0]  resolved_pc,
  output logic [GHR_W-1:0] ghr_history,
  output logic [XLEN-1:0]  bpu_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_o,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  logic            idle;
  logic            resolve;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] actual_npc;

  // The predictor's direction bit and the target LSB do not affect resolution.
  logic unused_bits;
  assign unused_bits = ex_pred_taken ^ ex_target[0];

  logic             branch_resolved_d, branch_resolved_q;
  logic             branch_taken_d,    branch_taken_q;
  logic [XLEN-1:0]  resolved_pc_d,     resolved_pc_q;
  logic [GHR_W-1:0] ghr_history_d,     ghr_history_q;
  logic [XLEN-1:0]  bpu_target_d,      bpu_target_q;
  logic             redirect_valid_d,  redirect_valid_q;
  logic [XLEN-1:0]  redirect_pc_d,     redirect_pc_q;

  always_comb begin
    resolve    = ex_valid & (ex_is_branch | ex_is_jump) & ~ex_stall & idle;
    taken      = ex_is_jump | ex_cond_true;
    tgt        = {ex_target[XLEN-1:1], 1'b0};
    actual_npc = taken ? tgt : ex_pc + XLEN'(INSTR_BYTES);
    mispredict = resolve & (actual_npc != ex_pred_pc);
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    branch_resolved_d = 1'b0;
    redirect_valid_d  = 1'b0;
    branch_taken_d    = branch_taken_q;
    resolved_pc_d     = resolved_pc_q;
    ghr_history_d     = ghr_history_q;
    bpu_target_d      = bpu_target_q;
    redirect_pc_d     = redirect_pc_q;
    if (resolve) begin
      branch_resolved_d = 1'b1;
      branch_taken_d    = taken;
      resolved_pc_d     = ex_pc;
      ghr_history_d     = ex_ghr;
      bpu_target_d      = tgt;
      if (mispredict) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = actual_npc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_resolved_q <= 1'b0;
      branch_taken_q    <= 1'b0;
      resolved_pc_q     <= '0;
      ghr_history_q     <= '0;
      bpu_target_q      <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_pc_q     <= '0;
    end else begin
      branch_resolved_q <= branch_resolved_d;
      branch_taken_q    <= branch_taken_d;
      resolved_pc_q     <= resolved_pc_d;
      ghr_history_q     <= ghr_history_d;
      bpu_target_q      <= bpu_target_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_pc_q     <= redirect_pc_d;
    end
  end

  bru_flush_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_ctrl (
    .clk       (clk),
    .rst       (rst),
    .mispredict(mispredict),
    .flush_o   (flush_o),
    .idle      (idle)
  );

  assign branch_resolved = branch_resolved_q;
  assign branch_taken    = branch_taken_q;
  assign resolved_pc     = resolved_pc_q;
  assign ghr_history     = ghr_history_q;
  assign bpu_target      = bpu_target_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_branches_d,    perf_branches_q;
  logic [CNT_W-1:0] perf_mispredicts_d, perf_mispredicts_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (resolve && !(&perf_branches_q)) begin
      perf_branches_d = perf_branches_q + 1'b1;
    end
    if (mispredict && !(&perf_mispredicts_q)) begin
      perf_mispredicts_d = perf_mispredicts_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default FLUSH_CYCLES=2).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_cond_true, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic [3:0]  ex_ghr;
  logic        branch_resolved, branch_taken, redirect_valid, flush_o;
  logic [31:0] resolved_pc, bpu_target, redirect_pc, perf_branches, perf_mispredicts;
  logic [3:0]  ghr_history;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_stall        (ex_stall),
    .ex_is_branch    (ex_is_branch),
    .ex_is_jump      (ex_is_jump),
    .ex_cond_true    (ex_cond_true),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_pc      (ex_pred_pc),
    .ex_ghr          (ex_ghr),
    .branch_resolved (branch_resolved),
    .branch_taken    (branch_taken),
    .resolved_pc     (resolved_pc),
    .ghr_history     (ghr_history),
    .bpu_target      (bpu_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_o         (flush_o),
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic br, input logic jp,
                       input logic cond, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [31:0] ppc, input logic [3:0] ghr);
    ex_valid      = v;
    ex_stall      = st;
    ex_is_branch  = br;
    ex_is_jump    = jp;
    ex_cond_true  = cond;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_pc    = ppc;
    ex_pred_taken = (ppc != pc + 32'd4);
    ex_ghr        = ghr;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected perf values collapse to zero when counters are not built.
  function automatic logic [31:0] perf(input int n);
`ifdef BRU_PERF_CNT_EN
    return 32'(n);
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  initial begin
    rst = 1'b0;
    idle_in();
    #12;
    check("rst_resolved", branch_resolved, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_flush", flush_o, 0);
    check("rst_resolved_pc", resolved_pc, 0);
    check("rst_perf_br", perf_branches, 0);
    rst = 1'b1;
    tick();

    // Correctly predicted taken BEQ
    drive(1, 0, 1, 0, 1, 32'h100, 32'h140, 32'h140, 4'hA);
    tick();
    check("beq_resolved", branch_resolved, 1);
    check("beq_taken", branch_taken, 1);
    check("beq_pc", resolved_pc, 32'h100);
    check("beq_ghr", ghr_history, 4'hA);
    check("beq_target", bpu_target, 32'h140);
    check("beq_redirect", redirect_valid, 0);
    check("beq_flush", flush_o, 0);
    idle_in();
    tick();
    check("beq_pulse_end", branch_resolved, 0);
    check("beq_pc_hold", resolved_pc, 32'h100);

    // Back-to-back correct branches; second has branch+jump set with cond=0
    drive(1, 0, 1, 0, 0, 32'h110, 32'h150, 32'h114, 4'h1);
    tick();
    check("b2b0_resolved", branch_resolved, 1);
    check("b2b0_taken", branch_taken, 0);
    check("b2b0_pc", resolved_pc, 32'h110);
    drive(1, 0, 1, 1, 0, 32'h120, 32'h180, 32'h180, 4'h2);
    tick();
    check("b2b1_resolved", branch_resolved, 1);
    check("b2b1_taken", branch_taken, 1);
    check("b2b1_pc", resolved_pc, 32'h120);
    check("b2b1_target", bpu_target, 32'h180);
    check("b2b1_redirect", redirect_valid, 0);
    check("b2b1_flush", flush_o, 0);

    // Wrong-target BNE; a valid branch held during the flush must be ignored
    drive(1, 0, 1, 0, 1, 32'h200, 32'h280, 32'h204, 4'h3);
    tick();
    check("bne_resolved", branch_resolved, 1);
    check("bne_redirect", redirect_valid, 1);
    check("bne_redirect_pc", redirect_pc, 32'h280);
    check("bne_flush1", flush_o, 1);
    drive(1, 0, 1, 0, 1, 32'h204, 32'h400, 32'h208, 4'h4);
    tick();
    check("bne_flush2", flush_o, 1);
    check("bne_fl_resolved", branch_resolved, 0);
    check("bne_fl_redirect", redirect_valid, 0);
    check("bne_fl_pc_hold", resolved_pc, 32'h200);
    tick();
    check("bne_flush_end", flush_o, 0);
    check("bne_fl2_resolved", branch_resolved, 0);
    check("bne_fl2_redirect", redirect_valid, 0);
    idle_in();

    // Wrong-direction BEQ: predicted taken, actually falls through
    drive(1, 0, 1, 0, 0, 32'h300, 32'h340, 32'h340, 4'h5);
    tick();
    check("nt_resolved", branch_resolved, 1);
    check("nt_taken", branch_taken, 0);
    check("nt_redirect", redirect_valid, 1);
    check("nt_redirect_pc", redirect_pc, 32'h304);
    check("nt_target", bpu_target, 32'h340);
    check("nt_perf_br", perf_branches, perf(5));
    check("nt_perf_mp", perf_mispredicts, perf(2));
    idle_in();
    tick();
    check("nt_redirect_pc_hold", redirect_pc, 32'h304);
    tick();
    check("nt_flush_end", flush_o, 0);

    // JALR at top of address space with odd target
    drive(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h1001, 32'h0, 4'h6);
    tick();
    check("jalr_taken", branch_taken, 1);
    check("jalr_target", bpu_target, 32'h1000);
    check("jalr_redirect", redirect_valid, 1);
    check("jalr_redirect_pc", redirect_pc, 32'h1000);
    idle_in();
    tick();
    tick();
    check("jalr_flush_end", flush_o, 0);
    drive(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h2000, 32'h0, 4'h7);
    tick();
    check("wrap_resolved", branch_resolved, 1);
    check("wrap_taken", branch_taken, 0);
    check("wrap_redirect", redirect_valid, 0);
    check("wrap_flush", flush_o, 0);

    // Stall holds the branch for three cycles
    drive(1, 1, 1, 0, 1, 32'h500, 32'h540, 32'h540, 4'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_pulse", branch_resolved, 0);
    end
    ex_stall = 1'b0;
    tick();
    check("stall_release", branch_resolved, 1);
    check("stall_pc", resolved_pc, 32'h500);
    idle_in();
    tick();
    check("stall_single", branch_resolved, 0);
    check("stall_perf_br", perf_branches, perf(8));
    check("stall_perf_mp", perf_mispredicts, perf(3));

    // Asynchronous reset during the first flush cycle
    drive(1, 0, 1, 0, 1, 32'h600, 32'h700, 32'h604, 4'h9);
    tick();
    check("mr_flush", flush_o, 1);
    idle_in();
    #1;
    rst = 1'b0;
    #1;
    check("mr_flush_clr", flush_o, 0);
    check("mr_redirect_clr", redirect_valid, 0);
    check("mr_resolved_clr", branch_resolved, 0);
    check("mr_redirect_pc_clr", redirect_pc, 0);
    check("mr_perf_br_clr", perf_branches, 0);
    check("mr_perf_mp_clr", perf_mispredicts, 0);
    #3;
    rst = 1'b1;
    tick();
    check("mr_flush_post", flush_o, 0);
    drive(1, 0, 1, 0, 0, 32'h700, 32'h800, 32'h704, 4'hB);
    tick();
    check("mr_resolve_after", branch_resolved, 1);
    check("mr_ghr_after", ghr_history, 4'hB);
    check("mr_perf_after", perf_branches, perf(1));
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
